// File: rtl/alu_rr_sched_pkg.sv
// Shared types for the round-robin ALU scheduler: op encoding and result-buffer states.
package alu_rr_sched_pkg;

    localparam int OP_W = 2;

    typedef enum logic [OP_W-1:0] {
        OP_ADD    = 2'b00,
        OP_SUB    = 2'b01,
        OP_MUL    = 2'b10,
        OP_PASS_B = 2'b11
    } op_t;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } buf_state_t;

endpackage

// File: rtl/alu_rr_sched_alu.sv
// Combinational unsigned add/sub/mul/pass unit with overflow flag.
// ALU_SAT_EN defined: overflowing results clamp (all-ones for ADD/MUL, zero on SUB borrow).
import alu_rr_sched_pkg::*;

module alu_rr_sched_alu #(
    parameter int W = 2
) (
    input  op_t          op,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] data,
    output logic         ovf
);

    logic [2*W-1:0] wide;
    logic [2*W-1:0] a_ext;
    logic [2*W-1:0] b_ext;

    assign a_ext = {{W{1'b0}}, a};
    assign b_ext = {{W{1'b0}}, b};

    always_comb begin
        wide = '0;
        ovf  = 1'b0;
        case (op)
            OP_ADD: begin
                wide = a_ext + b_ext;
                ovf  = |wide[2*W-1:W];
            end
            OP_SUB: begin
                wide = a_ext - b_ext;
                ovf  = (a < b);
            end
            OP_MUL: begin
                wide = a_ext * b_ext;
                ovf  = |wide[2*W-1:W];
            end
            default: begin
                wide = b_ext;
                ovf  = 1'b0;
            end
        endcase

        data = wide[W-1:0];
`ifdef ALU_SAT_EN
        if (ovf) begin
            data = (op == OP_SUB) ? '0 : '1;
        end
`endif
    end

endmodule

// File: rtl/alu_rr_sched.sv
// Round-robin arbiter sharing one ALU between NREQ requesters, with a one-entry result buffer.
// Result saturation is selected by ALU_SAT_EN inside alu_rr_sched_alu.
//
// state    | meaning
// ST_EMPTY | no result held; any granted request is accepted
// ST_FULL  | result held on rsp_*; new accept only when rsp_ready drains it
import alu_rr_sched_pkg::*;

module alu_rr_sched #(
    parameter int NREQ  = 4,
    parameter int W     = 2,
    parameter int CNT_W = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NREQ-1:0]         req_valid,
    output logic [NREQ-1:0]         req_ready,
    input  logic [2*NREQ-1:0]       req_op,
    input  logic [W*NREQ-1:0]       req_a,
    input  logic [W*NREQ-1:0]       req_b,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [$clog2(NREQ)-1:0] rsp_id,
    output logic [W-1:0]            rsp_data,
    output logic                    rsp_ovf,
    output logic [CNT_W-1:0]        served_cnt
);

    localparam int ID_W = $clog2(NREQ);

    buf_state_t      state_q;
    logic [ID_W-1:0] ptr_q;
    logic [ID_W-1:0] id_q;
    logic [W-1:0]    data_q;
    logic            ovf_q;
    logic [CNT_W-1:0] cnt_q;

    logic            slot_free;
    logic            gnt_found;
    logic [ID_W-1:0] gnt_idx;
    logic            accept;
    op_t             alu_op;
    logic [W-1:0]    alu_a;
    logic [W-1:0]    alu_b;
    logic [W-1:0]    alu_data;
    logic            alu_ovf;

    assign slot_free = (state_q == ST_EMPTY) || rsp_ready;

    // Scan starts just after the last granted requester so it gets lowest priority.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        for (int k = 1; k <= NREQ; k++) begin
            if (!gnt_found && req_valid[(int'(ptr_q) + k) % NREQ]) begin
                gnt_found = 1'b1;
                gnt_idx   = ID_W'((int'(ptr_q) + k) % NREQ);
            end
        end
    end

    assign accept    = gnt_found && slot_free;
    assign req_ready = accept ? (NREQ'(1) << gnt_idx) : '0;

    assign alu_op = op_t'(req_op[OP_W*int'(gnt_idx) +: OP_W]);
    assign alu_a  = req_a[W*int'(gnt_idx) +: W];
    assign alu_b  = req_b[W*int'(gnt_idx) +: W];

    alu_rr_sched_alu #(
        .W (W)
    ) u_alu (
        .op   (alu_op),
        .a    (alu_a),
        .b    (alu_b),
        .data (alu_data),
        .ovf  (alu_ovf)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_EMPTY;
            ptr_q   <= ID_W'(NREQ - 1);
            id_q    <= '0;
            data_q  <= '0;
            ovf_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (accept) begin
                        state_q <= ST_FULL;
                    end
                end
                ST_FULL: begin
                    if (!accept && rsp_ready) begin
                        state_q <= ST_EMPTY;
                    end
                end
                default: state_q <= ST_EMPTY;
            endcase

            if (accept) begin
                ptr_q  <= gnt_idx;
                id_q   <= gnt_idx;
                data_q <= alu_data;
                ovf_q  <= alu_ovf;
                cnt_q  <= cnt_q + CNT_W'(1);
            end
        end
    end

    assign rsp_valid  = (state_q == ST_FULL);
    assign rsp_id     = id_q;
    assign rsp_data   = data_q;
    assign rsp_ovf    = ovf_q;
    assign served_cnt = cnt_q;

endmodule

// File: tb/tb_alu_rr_sched.sv
// Bench for alu_rr_sched: queue-free behavioural model checked every cycle plus directed literal checks.
module tb_alu_rr_sched;

    localparam int NREQ  = 4;
    localparam int W     = 2;
    localparam int CNT_W = 16;
    localparam int MAXV  = (1 << W) - 1;

    logic                    clk;
    logic                    reset;
    logic [NREQ-1:0]         req_valid;
    logic [NREQ-1:0]         req_ready;
    logic [2*NREQ-1:0]       req_op;
    logic [W*NREQ-1:0]       req_a;
    logic [W*NREQ-1:0]       req_b;
    logic                    rsp_valid;
    logic                    rsp_ready;
    logic [$clog2(NREQ)-1:0] rsp_id;
    logic [W-1:0]            rsp_data;
    logic                    rsp_ovf;
    logic [CNT_W-1:0]        served_cnt;

    int total = 0;
    int bad   = 0;
    logic cnt_load = 1'b0;

    alu_rr_sched #(.NREQ(NREQ), .W(W), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_a      (req_a),
        .req_b      (req_b),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_data   (rsp_data),
        .rsp_ovf    (rsp_ovf),
        .served_cnt (served_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit m_full;
    int m_ptr, m_id, m_data, m_ovf;
    int m_cnt;

    // Winner is the valid requester at the smallest rotational distance after ptr.
    function automatic int model_grant(input logic [NREQ-1:0] v, input int ptr);
        int best = -1;
        int bestd = NREQ;
        for (int i = 0; i < NREQ; i++) begin
            int d;
            d = (i - ptr - 1 + 2 * NREQ) % NREQ;
            if (v[i] && d < bestd) begin
                bestd = d;
                best  = i;
            end
        end
        return best;
    endfunction

    task automatic model_alu(input int op, input int a, input int b, output int d, output int o);
        int r;
        case (op)
            0: r = a + b;
            1: r = a - b;
            2: r = a * b;
            default: r = b;
        endcase
        o = (r < 0 || r > MAXV) ? 1 : 0;
`ifdef ALU_SAT_EN
        d = (r < 0) ? 0 : (r > MAXV) ? MAXV : r;
`else
        d = ((r % (MAXV + 1)) + (MAXV + 1)) % (MAXV + 1);
`endif
    endtask

    function automatic logic [NREQ-1:0] model_ready();
        int g;
        g = model_grant(req_valid, m_ptr);
        if (g >= 0 && (!m_full || rsp_ready)) return NREQ'(1) << g;
        return '0;
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            m_full = 0; m_ptr = NREQ - 1; m_id = 0; m_data = 0; m_ovf = 0; m_cnt = 0;
        end else begin
            int g, d, o;
            g = model_grant(req_valid, m_ptr);
            if (cnt_load) m_cnt = 32'hFFFF;
            if (g >= 0 && (!m_full || rsp_ready)) begin
                model_alu(int'(req_op[2*g +: 2]), int'(req_a[W*g +: W]), int'(req_b[W*g +: W]), d, o);
                m_full = 1; m_ptr = g; m_id = g; m_data = d; m_ovf = o;
                m_cnt = (m_cnt + 1) % (1 << CNT_W);
            end else if (rsp_ready) begin
                m_full = 0;
            end
        end
    end

    initial begin
        @(posedge clk);
        forever begin
            @(negedge clk);
            check("mdl_req_ready", longint'(req_ready), longint'(model_ready()));
            check("mdl_rsp_valid", longint'(rsp_valid), longint'(m_full));
            check("mdl_rsp_id",    longint'(rsp_id),    longint'(m_id));
            check("mdl_rsp_data",  longint'(rsp_data),  longint'(m_data));
            check("mdl_rsp_ovf",   longint'(rsp_ovf),   longint'(m_ovf));
            check("mdl_served",    longint'(served_cnt), longint'(m_cnt));
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input int op, input int a, input int b);
        req_op[2*i +: 2] = 2'(op);
        req_a[W*i +: W]  = W'(a);
        req_b[W*i +: W]  = W'(b);
    endtask

    int v_op[4]   = '{0, 1, 2, 3};
    int v_a[4]    = '{3, 1, 3, 1};
    int v_b[4]    = '{2, 2, 3, 2};
`ifdef ALU_SAT_EN
    int v_data[4] = '{3, 0, 3, 2};
`else
    int v_data[4] = '{1, 3, 1, 2};
`endif
    int v_ovf[4]  = '{1, 1, 1, 0};
    int g_seq[5]  = '{0, 1, 2, 3, 0};

    initial begin
        reset = 1'b1; req_valid = '0; req_op = '0; req_a = '0; req_b = '0; rsp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_rsp_valid", longint'(rsp_valid), 0);
        check("rst_served", longint'(served_cnt), 0);
        reset = 1'b0;

        // 1: single ADD from req0
        set_req(0, 0, 1, 2);
        req_valid = 4'b0001;
        @(negedge clk);
        check("t1_req_ready", longint'(req_ready), 1);
        cyc();
        req_valid = '0;
        @(negedge clk);
        check("t1_rsp_valid", longint'(rsp_valid), 1);
        check("t1_rsp_id", longint'(rsp_id), 0);
        check("t1_rsp_data", longint'(rsp_data), 3);
        check("t1_rsp_ovf", longint'(rsp_ovf), 0);
        check("t1_served", longint'(served_cnt), 1);

        // 2: arithmetic vectors on req3 (leaves pointer at 3)
        for (int k = 0; k < 4; k++) begin
            cyc();
            set_req(3, v_op[k], v_a[k], v_b[k]);
            req_valid = 4'b1000;
            cyc();
            req_valid = '0;
            @(negedge clk);
            check("t2_data", longint'(rsp_data), longint'(v_data[k]));
            check("t2_ovf", longint'(rsp_ovf), longint'(v_ovf[k]));
        end

        // 3: all valid, back-to-back round robin
        cyc();
        for (int i = 0; i < NREQ; i++) set_req(i, 3, 0, i);
        req_valid = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("t3_grant", longint'(req_ready), longint'(1 << g_seq[k]));
            if (k > 0) check("t3_rsp_id", longint'(rsp_id), longint'(g_seq[k-1]));
            cyc();
        end
        req_valid = '0;
        cyc();

        // 4: stall while FULL, then drain and grant in one cycle
        rsp_ready = 1'b0;
        set_req(0, 0, 1, 1);
        req_valid = 4'b0001;
        cyc();
        req_valid = 4'b0110;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("t4_stall_ready", longint'(req_ready), 0);
            check("t4_stall_valid", longint'(rsp_valid), 1);
            check("t4_stall_id", longint'(rsp_id), 0);
            check("t4_stall_data", longint'(rsp_data), 2);
            cyc();
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        check("t4_drain_grant", longint'(req_ready), 2);
        cyc();
        check("t4_new_id", longint'(rsp_id), 1);
        check("t4_new_valid", longint'(rsp_valid), 1);

        // 5: reset while FULL and stalled
        rsp_ready = 1'b0;
        cyc();
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        req_valid = 4'b0111;
        @(negedge clk);
        check("t5_rsp_valid", longint'(rsp_valid), 0);
        check("t5_served", longint'(served_cnt), 0);
        check("t5_grant_req0", longint'(req_ready), 1);
        cyc();
        req_valid = '0;
        rsp_ready = 1'b1;
        cyc();

        // 6: counter wrap
        @(negedge clk);
        #2;
        force dut.cnt_q = 16'hFFFF;
        cnt_load = 1'b1;
        #1;
        release dut.cnt_q;
        req_valid = 4'b0001;
        cyc();
        cnt_load = 1'b0;
        req_valid = '0;
        @(negedge clk);
        check("t6_served_wrap", longint'(served_cnt), 0);

        repeat (3) cyc();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
